// File: rtl/rv32_div_sequencer_pkg.sv
// Shared encodings and types for the RV32M divide sequencer: op codes, FSM states,
// the restoring-division accumulator, and the iteration-count helper.
`ifndef RV32_DIV_SEQUENCER_PKG_SV
`define RV32_DIV_SEQUENCER_PKG_SV

package rv32_div_sequencer_pkg;

    localparam int unsigned RV32_XLEN = 32;

    // funct3[1:0] of the RV32M divide group
    localparam logic [1:0] RV32_DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] RV32_DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] RV32_DIV_OP_REM  = 2'b10;
    localparam logic [1:0] RV32_DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Partial remainder carries one extra bit to hold the subtract borrow.
    typedef struct packed {
        logic [RV32_XLEN:0]   rem;
        logic [RV32_XLEN-1:0] quot;
    } div_acc_t;

    function automatic int unsigned rv32_div_iters(input int unsigned steps);
        return RV32_XLEN / steps;
    endfunction

endpackage

`endif

// File: rtl/rv32_div_step.sv
// One combinational restoring-division step: shift {rem,quot} left by one, trial-subtract
// the divisor, and keep the difference when it does not borrow.
module rv32_div_step
    import rv32_div_sequencer_pkg::*;
(
    input  div_acc_t    acc_in,
    input  logic [31:0] divisor,
    output div_acc_t    acc_out
);

    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        rem_msb_unused;

    assign rem_sh = {acc_in.rem[31:0], acc_in.quot[31]};
    assign diff   = rem_sh - {1'b0, divisor};

    assign acc_out.rem  = diff[32] ? rem_sh : diff;
    assign acc_out.quot = {acc_in.quot[30:0], ~diff[32]};

    // Running remainder is always below the divisor, so its top bit never matters here.
    assign rem_msb_unused = acc_in.rem[32];

endmodule

// File: rtl/rv32_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit beside execute: accepts one divide, stalls
// the pipeline while iterating, and presents the result for the cycle execute latches it.
module rv32_div_sequencer
    import rv32_div_sequencer_pkg::*;
#(
    parameter int unsigned STEPS_PER_CYCLE = 1
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        start_in,
    input  logic [1:0]  op_in,
    input  logic [31:0] dividend_in,
    input  logic [31:0] divisor_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] result_out
);

    localparam int unsigned ITERS = rv32_div_iters(STEPS_PER_CYCLE);
    localparam int unsigned CNT_W = $clog2(ITERS);

    div_state_e       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       op_q,       op_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q,  neg_rem_d;
    div_acc_t         acc_q,      acc_d;
    logic [31:0]      dvs_q,      dvs_d;
    logic             valid_q,    valid_d;
    logic [31:0]      result_q,   result_d;

    // Operand conditioning for the accept cycle
    logic        in_signed;
    logic        in_rem;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic        sgn_ovf;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [31:0] special_res;

    assign in_signed   = (op_in == RV32_DIV_OP_DIV) || (op_in == RV32_DIV_OP_REM);
    assign in_rem      = (op_in == RV32_DIV_OP_REM) || (op_in == RV32_DIV_OP_REMU);
    assign a_neg       = in_signed && dividend_in[31];
    assign b_neg       = in_signed && divisor_in[31];
    assign a_abs       = a_neg ? 32'(~dividend_in + 32'd1) : dividend_in;
    assign b_abs       = b_neg ? 32'(~divisor_in + 32'd1) : divisor_in;
    assign div_zero    = (divisor_in == 32'd0);
    assign sgn_ovf     = in_signed && (dividend_in == 32'h8000_0000) && (divisor_in == 32'hFFFF_FFFF);
    assign special_res = div_zero ? (in_rem ? dividend_in : 32'hFFFF_FFFF)
                                  : (in_rem ? 32'd0 : 32'h8000_0000);

    // Chain of restoring steps applied in one BUSY cycle
    div_acc_t chain [STEPS_PER_CYCLE+1];

    assign chain[0] = acc_q;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        rv32_div_step u_step (
            .acc_in  (chain[g]),
            .divisor (dvs_q),
            .acc_out (chain[g+1])
        );
    end

    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fin_res;
    logic        fin_rem_msb_unused;

    assign quot_fix = neg_quot_q ? 32'(~chain[STEPS_PER_CYCLE].quot + 32'd1)
                                 : chain[STEPS_PER_CYCLE].quot;
    assign rem_fix  = neg_rem_q ? 32'(~chain[STEPS_PER_CYCLE].rem[31:0] + 32'd1)
                                : chain[STEPS_PER_CYCLE].rem[31:0];
    assign fin_res  = ((op_q == RV32_DIV_OP_REM) || (op_q == RV32_DIV_OP_REMU)) ? rem_fix : quot_fix;
    assign fin_rem_msb_unused = chain[STEPS_PER_CYCLE].rem[32];

    // Next-state and datapath update; flush overrides everything else
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        acc_d      = acc_q;
        dvs_d      = dvs_q;
        result_d   = result_q;

        if (flush_in) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_in) begin
                        op_d       = op_in;
                        neg_quot_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        acc_d.rem  = '0;
                        acc_d.quot = a_abs;
                        dvs_d      = b_abs;
                        if (div_zero || sgn_ovf) begin
                            result_d = special_res;
                            state_d  = DIV_DONE;
                        end else begin
                            cnt_d   = CNT_W'(ITERS - 1);
                            state_d = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    acc_d = chain[STEPS_PER_CYCLE];
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        result_d = fin_res;
                        state_d  = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!stall_in) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end

        valid_d = (state_d == DIV_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_q      <= '0;
            dvs_q      <= '0;
            valid_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            acc_q      <= acc_d;
            dvs_q      <= dvs_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
        end
    end

    // DONE drops the stall so execute advances and latches the result
    assign stall_out  = !flush_in && (((state_q == DIV_IDLE) && start_in) || (state_q == DIV_BUSY));
    assign valid_out  = valid_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_rv32_div_sequencer.sv
// Directed and random bench for rv32_div_sequencer against an arithmetic reference model,
// covering the default single-step build and a four-steps-per-cycle build.
module tb_rv32_div_sequencer;

    localparam int unsigned ITERS1 = 32;
    localparam int unsigned ITERS4 = 8;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        stall_in, flush_in, start_in;
    logic [1:0]  op_in;
    logic [31:0] dividend_in, divisor_in;
    logic        stall0, valid0;
    logic [31:0] res0;

    logic        start4;
    logic [1:0]  op4;
    logic [31:0] a4, b4;
    logic        stall4, valid4;
    logic [31:0] res4;
    logic        tie0;
    assign tie0 = 1'b0;

    rv32_div_sequencer #(.STEPS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
        .start_in(start_in), .op_in(op_in), .dividend_in(dividend_in), .divisor_in(divisor_in),
        .stall_out(stall0), .valid_out(valid0), .result_out(res0)
    );

    rv32_div_sequencer #(.STEPS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .stall_in(tie0), .flush_in(tie0),
        .start_in(start4), .op_in(op4), .dividend_in(a4), .divisor_in(b4),
        .stall_out(stall4), .valid_out(valid4), .result_out(res4)
    );

    // Reference: RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        bit is_rem = op[1];
        bit is_sgn = !op[0];
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input int unsigned iters);
        if (b == 32'd0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return int'(iters) + 2;
    endfunction

    int checks = 0;
    int passes = 0;

    // Driver-owned expectation and probe fields
    bit          run0 = 0, run4 = 0;
    int          e_seq0 = 0, e_seq4 = 0;
    string       e_name0 = "", e_name4 = "";
    logic [1:0]  e_op0, e_op4;
    logic [31:0] e_a0, e_b0, e_lit0, e_a4, e_b4;
    bit          e_lit_en0 = 0;
    bit          pr_en = 0, pr_valid = 0, pr_stall = 0, pr_chk_res = 0;
    logic [31:0] pr_res = '0;
    string       pr_name = "";
    event        ev0, ev4;

    // Monitor-owned tracking
    int seen0 = 0, seen4 = 0;
    int cnt0 = 0, stl0 = 0, cnt4 = 0, stl4 = 0;
    bit done0 = 1, done4 = 1;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Single compare process
    always @(negedge clk) begin
        int lat;
        logic [31:0] m;
        if (e_seq0 != seen0) begin seen0 = e_seq0; cnt0 = 0; stl0 = 0; done0 = 0; end
        if (run0 && !done0) begin
            cnt0++;
            if (stall0) stl0++;
            if (valid0 === 1'b1) begin
                lat = exp_lat(e_op0, e_a0, e_b0, ITERS1);
                m   = model(e_op0, e_a0, e_b0);
                check({e_name0, "_model"}, res0 === m, res0, m);
                if (e_lit_en0) check({e_name0, "_lit"}, res0 === e_lit0, res0, e_lit0);
                check({e_name0, "_valid_cycle"}, cnt0 == lat, 32'(cnt0), 32'(lat));
                check({e_name0, "_stall_cycles"}, stl0 == lat - 1, 32'(stl0), 32'(lat - 1));
                done0 = 1;
                ->ev0;
            end else if (cnt0 > 80) begin
                check({e_name0, "_timeout"}, 1'b0, 32'(cnt0), 32'd80);
                done0 = 1;
                ->ev0;
            end
        end else if (!run0 && valid0 === 1'b1) begin
            check("stray_valid0", 1'b0, 32'd1, 32'd0);
        end

        if (e_seq4 != seen4) begin seen4 = e_seq4; cnt4 = 0; stl4 = 0; done4 = 0; end
        if (run4 && !done4) begin
            cnt4++;
            if (stall4) stl4++;
            if (valid4 === 1'b1) begin
                lat = exp_lat(op4, a4, b4, ITERS4);
                m   = model(op4, a4, b4);
                check({e_name4, "_model"}, res4 === m, res4, m);
                check({e_name4, "_stall_cycles"}, stl4 == lat - 1, 32'(stl4), 32'(lat - 1));
                done4 = 1;
                ->ev4;
            end else if (cnt4 > 40) begin
                check({e_name4, "_timeout"}, 1'b0, 32'(cnt4), 32'd40);
                done4 = 1;
                ->ev4;
            end
        end else if (!run4 && valid4 === 1'b1) begin
            check("stray_valid4", 1'b0, 32'd1, 32'd0);
        end

        if (pr_en) begin
            check({pr_name, "_valid"}, valid0 === pr_valid, 32'(valid0), 32'(pr_valid));
            check({pr_name, "_stall"}, stall0 === pr_stall, 32'(stall0), 32'(pr_stall));
            if (pr_chk_res) check({pr_name, "_result"}, res0 === pr_res, res0, pr_res);
        end
    end

    task automatic probe(input string name, input bit v, input bit s, input logic [31:0] r, input bit chk);
        pr_name = name; pr_valid = v; pr_stall = s; pr_res = r; pr_chk_res = chk; pr_en = 1;
    endtask

    // Called at posedge+1 with the DUT in IDLE
    task automatic start0(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input bit lit_en);
        e_name0 = name; e_op0 = op; e_a0 = a; e_b0 = b; e_lit0 = lit; e_lit_en0 = lit_en;
        start_in = 1; op_in = op; dividend_in = a; divisor_in = b;
        run0 = 1;
        e_seq0++;
    endtask

    task automatic op0(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input bit b2b);
        start0(name, op, a, b, lit, 1'b1);
        @(ev0);
        @(posedge clk); #1;
        if (!b2b) begin start_in = 0; run0 = 0; end
    endtask

    task automatic do_op4(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        e_name4 = name; start4 = 1; op4 = op; a4 = a; b4 = b; run4 = 1;
        e_seq4++;
        @(ev4);
        @(posedge clk); #1;
        start4 = 0; run4 = 0;
    endtask

    initial begin
        reset_n = 0; stall_in = 0; flush_in = 0; start_in = 0;
        op_in = '0; dividend_in = '0; divisor_in = '0;
        start4 = 0; op4 = '0; a4 = '0; b4 = '0;
        probe("reset", 1'b0, 1'b0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1; pr_en = 0;

        // Normal latency, back-to-back acceptance, signed rules
        op0("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        op0("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
        op0("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        op0("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        op0("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        op0("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        op0("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        op0("remu_max_16",OP_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 1'b0);
        op0("div_min_2",  OP_DIV,  32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0);

        // Special cases: one stall cycle, valid in cycle 2
        op0("div_x_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        op0("remu_1234_0",OP_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0);
        op0("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        op0("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Flush at BUSY cycle 10 aborts with no result
        start_in = 1; op_in = OP_DIVU; dividend_in = 32'd1000; divisor_in = 32'd3;
        repeat (9) @(posedge clk);
        #1 probe("busy9", 1'b0, 1'b1, 32'd0, 1'b0);
        @(posedge clk); #1;
        flush_in = 1;
        probe("flush_cycle", 1'b0, 1'b0, 32'd0, 1'b0);
        @(posedge clk); #1;
        flush_in = 0; start_in = 0;
        probe("post_flush", 1'b0, 1'b0, 32'd0, 1'b0);
        @(posedge clk); #1 pr_en = 0;
        repeat (40) @(posedge clk);
        #1 op0("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

        // stall_in holds DONE: valid and result stay for three cycles
        stall_in = 1;
        start0("stall_hold", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        @(ev0);
        @(posedge clk); #1;
        probe("done_hold2", 1'b1, 1'b0, 32'd14, 1'b1);
        @(posedge clk); #1;
        stall_in = 0;
        probe("done_hold3", 1'b1, 1'b0, 32'd14, 1'b1);
        @(posedge clk); #1;
        start_in = 0; run0 = 0;
        probe("after_hold", 1'b0, 1'b0, 32'd0, 1'b0);
        @(posedge clk); #1 pr_en = 0;

        // Reset dropped mid-BUSY clears outputs at once
        start_in = 1; op_in = OP_DIVU; dividend_in = 32'd100; divisor_in = 32'd7;
        repeat (5) @(posedge clk);
        #1 reset_n = 0; start_in = 0;
        probe("reset_mid_busy", 1'b0, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1 reset_n = 1; pr_en = 0;
        repeat (40) @(posedge clk);
        #1 op0("remu_after_rst", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);

        // Four steps per cycle: random operands with special-case bias
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            int unsigned sel;
            a   = $urandom;
            b   = $urandom;
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op4($sformatf("rand4_%0d", i), op, a, b);
        end

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
